text_term_writer: RTL and testbench

- Upstream feeder for the 80x25 text-mode display: accepts a byte stream over a valid/ready handshake and writes character and colour cells into screen_ram and color_ram through their write port.
- Maintains a hardware cursor and interprets control codes: CR, LF, BS and FF (clear screen).
- Scrolls the screen up one row when output passes the last row.
- Cell addresses use the display's layout: addr[11:7] = row, addr[6:0] = column.

---
 rtl/text_term_writer_if.sv | 23 ++
 rtl/text_term_writer.sv | 194 +++++++++++++++++++
 tb/tb_text_term_writer.sv | 301 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/text_term_writer_if.sv
// text_term_writer_if: byte-stream handshake, shared RAM port and cursor bundle for the text-mode writer
interface text_term_writer_if;
    logic [7:0]  char_i;
    logic        char_valid_i;
    logic        char_ready_o;
    logic [7:0]  attr_i;
    logic [11:0] addr_o;
    logic [7:0]  char_data_o;
    logic [7:0]  colr_data_o;
    logic        wren_o;
    logic [7:0]  rd_char_i;
    logic [7:0]  rd_colr_i;
    logic [6:0]  cursor_x_o;
    logic [4:0]  cursor_y_o;
    modport slave (
        input  char_i, char_valid_i, attr_i, rd_char_i, rd_colr_i,
        output char_ready_o, addr_o, char_data_o, colr_data_o, wren_o, cursor_x_o, cursor_y_o
    );
    modport master (
        output char_i, char_valid_i, attr_i, rd_char_i, rd_colr_i,
        input  char_ready_o, addr_o, char_data_o, colr_data_o, wren_o, cursor_x_o, cursor_y_o
    );
endinterface

// File: rtl/text_term_writer.sv
// text_term_writer: terminal feeder turning a byte stream into character/colour cell writes,
// with cursor tracking, CR/LF/BS/FF handling and one-row scroll through the shared RAM port.
module text_term_writer #(
    parameter int         COLS       = 80,
    parameter int         ROWS       = 25,
    parameter int         RD_LAT     = 1,
    parameter logic [7:0] BLANK_CHAR = 8'h20,
    parameter logic [7:0] RST_ATTR   = 8'h70
) (
    input logic               clk,
    input logic               rst,
    text_term_writer_if.slave bus
);
    localparam int         WW       = RD_LAT > 1 ? $clog2(RD_LAT) : 1;
    localparam logic [6:0] LAST_COL = 7'(COLS - 1);
    localparam logic [4:0] LAST_ROW = 5'(ROWS - 1);
    localparam logic [7:0] BS = 8'h08, LF = 8'h0A, FF = 8'h0C, CR = 8'h0D;

    typedef enum logic [2:0] {CLEAR, IDLE, PUT, SCR_RD, SCR_WAIT, SCR_WR, SCR_CLR} state_t;

    state_t        state_q, state_d;
    logic [11:0]   addr_q, addr_d;
    logic [7:0]    chr_q, chr_d, clr_q, clr_d, byte_q, byte_d, attr_q, attr_d;
    logic          wren_q, wren_d, rdy_q, rdy_d;
    logic [6:0]    x_q, x_d, c_q, c_d;
    logic [4:0]    y_q, y_d, r_q, r_d;
    logic [WW-1:0] w_q, w_d;
    logic          go_idle, go_scr;

    function automatic logic [11:0] next_cell(input logic [11:0] a);
        return a[6:0] == LAST_COL ? {a[11:7] + 5'd1, 7'd0} : {a[11:7], a[6:0] + 7'd1};
    endfunction

    always_ff @(posedge clk or posedge rst)
        if (rst) begin
            state_q <= CLEAR;
            addr_q  <= '0;
            chr_q   <= '0;
            clr_q   <= '0;
            wren_q  <= 1'b0;
            rdy_q   <= 1'b0;
            x_q     <= '0;
            y_q     <= '0;
            r_q     <= '0;
            c_q     <= '0;
            w_q     <= '0;
            byte_q  <= '0;
            attr_q  <= RST_ATTR;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            chr_q   <= chr_d;
            clr_q   <= clr_d;
            wren_q  <= wren_d;
            rdy_q   <= rdy_d;
            x_q     <= x_d;
            y_q     <= y_d;
            r_q     <= r_d;
            c_q     <= c_d;
            w_q     <= w_d;
            byte_q  <= byte_d;
            attr_q  <= attr_d;
        end

    // Output registers are loaded with what the next state presents, so every output is registered.
    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        chr_d   = chr_q;
        clr_d   = clr_q;
        wren_d  = 1'b0;
        rdy_d   = 1'b0;
        x_d     = x_q;
        y_d     = y_q;
        r_d     = r_q;
        c_d     = c_q;
        w_d     = w_q;
        byte_d  = byte_q;
        attr_d  = attr_q;
        go_idle = 1'b0;
        go_scr  = 1'b0;
        case (state_q)
            CLEAR: begin
                // wren_q low means nothing has been written yet (first cycle after reset)
                if (wren_q && addr_q == {LAST_ROW, LAST_COL}) begin
                    go_idle = 1'b1;
                    x_d     = '0;
                    y_d     = '0;
                end else begin
                    addr_d = wren_q ? next_cell(addr_q) : '0;
                    chr_d  = BLANK_CHAR;
                    clr_d  = attr_q;
                    wren_d = 1'b1;
                end
            end
            IDLE: begin
                rdy_d = 1'b1;
                if (bus.char_valid_i && rdy_q) begin
                    byte_d = bus.char_i;
                    attr_d = bus.attr_i;
                    rdy_d  = bus.char_i == 8'h00;
                    if (bus.char_i == CR) x_d = '0;
                    else if (bus.char_i == LF && y_q == LAST_ROW) go_scr = 1'b1;
                    else if (bus.char_i == LF) begin
                        x_d = '0;
                        y_d = y_q + 5'd1;
                    end else if (bus.char_i == BS && x_q != '0) begin
                        state_d = PUT;
                        addr_d  = {y_q, x_q - 7'd1};
                        chr_d   = BLANK_CHAR;
                        clr_d   = bus.attr_i;
                        wren_d  = 1'b1;
                    end else if (bus.char_i == FF) begin
                        state_d = CLEAR;
                        addr_d  = '0;
                        chr_d   = BLANK_CHAR;
                        clr_d   = bus.attr_i;
                        wren_d  = 1'b1;
                    end else if (bus.char_i != 8'h00 && bus.char_i != BS) begin
                        state_d = PUT;
                        addr_d  = {y_q, x_q};
                        chr_d   = bus.char_i;
                        clr_d   = bus.attr_i;
                        wren_d  = 1'b1;
                    end
                end
            end
            PUT: begin
                if (byte_q == BS) begin
                    x_d     = addr_q[6:0];
                    go_idle = 1'b1;
                end else if (x_q != LAST_COL) begin
                    x_d     = x_q + 7'd1;
                    go_idle = 1'b1;
                end else if (y_q != LAST_ROW) begin
                    x_d     = '0;
                    y_d     = y_q + 5'd1;
                    go_idle = 1'b1;
                end else go_scr = 1'b1;
            end
            SCR_RD: begin
                state_d = SCR_WAIT;
                w_d     = '0;
            end
            SCR_WAIT:
                if (w_q == WW'(RD_LAT - 1)) begin
                    state_d = SCR_WR;
                    addr_d  = {r_q - 5'd1, c_q};
                    chr_d   = bus.rd_char_i;
                    clr_d   = bus.rd_colr_i;
                    wren_d  = 1'b1;
                end else w_d = w_q + WW'(1);
            SCR_WR:
                if (r_q == LAST_ROW && c_q == LAST_COL) begin
                    state_d = SCR_CLR;
                    addr_d  = {LAST_ROW, 7'd0};
                    chr_d   = BLANK_CHAR;
                    clr_d   = attr_q;
                    wren_d  = 1'b1;
                end else begin
                    state_d    = SCR_RD;
                    {r_d, c_d} = next_cell({r_q, c_q});
                    addr_d     = next_cell({r_q, c_q});
                end
            SCR_CLR:
                if (addr_q[6:0] == LAST_COL) begin
                    x_d     = '0;
                    go_idle = 1'b1;
                end else begin
                    addr_d = next_cell(addr_q);
                    wren_d = 1'b1;
                end
            default: state_d = CLEAR;
        endcase
        if (go_idle) begin
            state_d = IDLE;
            rdy_d   = 1'b1;
        end
        if (go_scr) begin
            state_d = SCR_RD;
            r_d     = 5'd1;
            c_d     = '0;
            addr_d  = {5'd1, 7'd0};
        end
    end

    assign bus.char_ready_o = rdy_q;
    assign bus.addr_o       = addr_q;
    assign bus.char_data_o  = chr_q;
    assign bus.colr_data_o  = clr_q;
    assign bus.wren_o       = wren_q;
    assign bus.cursor_x_o   = x_q;
    assign bus.cursor_y_o   = y_q;
endmodule

// File: tb/tb_text_term_writer.sv
// tb_text_term_writer: directed byte stimulus checked cycle by cycle against a cell-level screen model.
module tb_text_term_writer;
    localparam int COLS   = 80;
    localparam int ROWS   = 25;
    localparam int RD_LAT = 1;
    localparam int SCRL   = (ROWS - 1) * COLS * (2 + RD_LAT) + COLS;

    typedef struct packed {
        logic [11:0] a;
        logic [7:0]  ch;
        logic [7:0]  co;
    } wr_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    text_term_writer_if bus();
    text_term_writer dut (.clk(clk), .rst(rst), .bus(bus));
    always #5 clk = ~clk;

    logic [7:0]  sram [4096];
    logic [7:0]  cram [4096];
    logic [7:0]  msc  [4096];
    logic [7:0]  mco  [4096];
    logic [7:0]  rd_c, rd_a;
    logic        preload = 1'b0;
    wr_t         expq [$];
    wr_t         e;
    int          total = 0, bad = 0, nwr = 0, mx = 0, my = 0;
    logic [11:0] last_a = '0;
    logic [7:0]  last_ch = '0, last_co = '0;

    assign bus.rd_char_i = rd_c;
    assign bus.rd_colr_i = rd_a;

    // Display RAM pair with one cycle of read latency
    always @(posedge clk) begin
        rd_c <= sram[bus.addr_o];
        rd_a <= cram[bus.addr_o];
        if (bus.wren_o) begin
            sram[bus.addr_o] <= bus.char_data_o;
            cram[bus.addr_o] <= bus.colr_data_o;
        end
        if (preload)
            for (int r = 0; r < ROWS; r++)
                for (int c = 0; c < COLS; c++) begin
                    sram[{r[4:0], c[6:0]}] <= 8'(r);
                    cram[{r[4:0], c[6:0]}] <= 8'(r) ^ 8'hA5;
                end
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", nm, act, exp);
        end
    endtask

    task automatic mwr(input int r, input int c, input logic [7:0] ch, input logic [7:0] co);
        logic [11:0] a = {5'(r), 7'(c)};
        expq.push_back('{a, ch, co});
        msc[a] = ch;
        mco[a] = co;
    endtask

    task automatic mclear(input logic [7:0] at);
        for (int r = 0; r < ROWS; r++)
            for (int c = 0; c < COLS; c++) mwr(r, c, 8'h20, at);
    endtask

    task automatic mscroll(input logic [7:0] at);
        for (int r = 1; r < ROWS; r++)
            for (int c = 0; c < COLS; c++)
                mwr(r - 1, c, msc[{5'(r), 7'(c)}], mco[{5'(r), 7'(c)}]);
        for (int c = 0; c < COLS; c++) mwr(ROWS - 1, c, 8'h20, at);
    endtask

    task automatic mbyte(input logic [7:0] b, input logic [7:0] at, output int lat);
        lat = 1;
        if (b == 8'h00) lat = 0;
        else if (b == 8'h0D) mx = 0;
        else if (b == 8'h0A) begin
            mx = 0;
            if (my < ROWS - 1) my++;
            else begin
                mscroll(at);
                lat = SCRL;
            end
        end else if (b == 8'h08) begin
            if (mx > 0) begin
                mx--;
                mwr(my, mx, 8'h20, at);
            end
        end else if (b == 8'h0C) begin
            mclear(at);
            mx  = 0;
            my  = 0;
            lat = ROWS * COLS;
        end else begin
            mwr(my, mx, b, at);
            if (mx < COLS - 1) mx++;
            else begin
                mx = 0;
                if (my < ROWS - 1) my++;
                else begin
                    mscroll(at);
                    lat += SCRL;
                end
            end
        end
    endtask

    task automatic wait_ready(input int lim);
        int n = 0;
        while (!bus.char_ready_o && n < lim) begin
            @(negedge clk);
            n++;
        end
    endtask

    task automatic send(input logic [7:0] b, input logic [7:0] at, input bit wt, output int busy);
        int n = 0;
        int lat;
        busy = 0;
        @(negedge clk);
        bus.char_i       = b;
        bus.attr_i       = at;
        bus.char_valid_i = 1'b1;
        while (!bus.char_ready_o && n < 10000) begin
            @(negedge clk);
            n++;
        end
        chk("accept_wait", 32'(n < 10000), 1);
        @(posedge clk);
        #1;
        bus.char_valid_i = 1'b0;
        mbyte(b, at, lat);
        if (wt) begin
            n = 0;
            @(negedge clk);
            while (!bus.char_ready_o && n < 20000) begin
                busy++;
                @(negedge clk);
                n++;
            end
            chk("busy_cycles", busy, lat);
        end
    endtask

    always @(negedge clk)
        if (!rst) begin
            if (bus.wren_o) begin
                nwr++;
                last_a  = bus.addr_o;
                last_ch = bus.char_data_o;
                last_co = bus.colr_data_o;
                chk("wr_in_range", 32'(bus.addr_o[6:0] < 7'(COLS) && bus.addr_o[11:7] < 5'(ROWS)), 1);
                chk("wr_pending", 32'(expq.size() > 0), 1);
                if (expq.size() > 0) begin
                    e = expq.pop_front();
                    chk("wr_addr", bus.addr_o, e.a);
                    chk("wr_char", bus.char_data_o, e.ch);
                    chk("wr_colr", bus.colr_data_o, e.co);
                end
            end
            if (bus.char_ready_o) begin
                chk("cur_x", bus.cursor_x_o, mx);
                chk("cur_y", bus.cursor_y_o, my);
            end
        end

    initial begin
        #600000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int busy, w0;
        bus.char_i       = '0;
        bus.char_valid_i = 1'b0;
        bus.attr_i       = '0;
        mclear(8'h70);
        repeat (3) @(negedge clk);
        chk("rst_addr", bus.addr_o, 0);
        chk("rst_wren", bus.wren_o, 0);
        chk("rst_ready", bus.char_ready_o, 0);
        chk("rst_data", {bus.char_data_o, bus.colr_data_o}, 0);
        chk("rst_cx", bus.cursor_x_o, 0);
        chk("rst_cy", bus.cursor_y_o, 0);
        rst = 1'b0;
        wait_ready(5000);
        chk("clear_ready", bus.char_ready_o, 1);
        chk("clear_writes", nwr, 2000);
        chk("clear_left", expq.size(), 0);
        chk("clear_cx", bus.cursor_x_o, 0);
        chk("clear_cy", bus.cursor_y_o, 0);

        w0 = nwr;
        send(8'h41, 8'h1E, 1'b1, busy);
        chk("A_busy", busy, 1);
        chk("A_nwr", nwr - w0, 1);
        chk("A_addr", last_a, 12'h000);
        chk("A_data", {last_ch, last_co}, 16'h411E);
        chk("A_cx", bus.cursor_x_o, 1);
        chk("A_cy", bus.cursor_y_o, 0);

        repeat (2) send(8'h0A, 8'h07, 1'b1, busy);
        w0 = nwr;
        send(8'h08, 8'h1E, 1'b1, busy);
        chk("bs0_nwr", nwr - w0, 0);
        chk("bs0_cx", bus.cursor_x_o, 0);
        chk("bs0_cy", bus.cursor_y_o, 2);
        send(8'h61, 8'h07, 1'b1, busy);
        send(8'h62, 8'h07, 1'b1, busy);
        send(8'h63, 8'h07, 1'b1, busy);
        send(8'h08, 8'h07, 1'b1, busy);
        chk("bs_addr", last_a, 12'h102);
        chk("bs_data", {last_ch, last_co}, 16'h2007);
        chk("bs_cx", bus.cursor_x_o, 2);
        chk("bs_cy", bus.cursor_y_o, 2);

        send(8'h0A, 8'h07, 1'b1, busy);
        w0 = nwr;
        for (int i = 0; i < COLS; i++) send(8'h78, 8'h0E, 1'b1, busy);
        chk("row_nwr", nwr - w0, 80);
        chk("row_last", last_a, 12'h1CF);
        chk("row_cx", bus.cursor_x_o, 0);
        chk("row_cy", bus.cursor_y_o, 4);

        send(8'h71, 8'h0E, 1'b1, busy);
        send(8'h0D, 8'h0E, 1'b1, busy);
        chk("cr_busy", busy, 1);
        chk("cr_cx", bus.cursor_x_o, 0);
        w0 = nwr;
        send(8'h00, 8'h0E, 1'b1, busy);
        chk("nul_busy", busy, 0);
        chk("nul_nwr", nwr - w0, 0);

        repeat (20) send(8'h0A, 8'h07, 1'b1, busy);
        repeat (5) send(8'h79, 8'h07, 1'b1, busy);
        @(negedge clk);
        preload = 1'b1;
        for (int r = 0; r < ROWS; r++)
            for (int c = 0; c < COLS; c++) begin
                msc[{5'(r), 7'(c)}] = 8'(r);
                mco[{5'(r), 7'(c)}] = 8'(r) ^ 8'hA5;
            end
        @(negedge clk);
        preload = 1'b0;
        send(8'h0A, 8'h4F, 1'b1, busy);
        chk("scr_busy", busy, 5840);
        chk("scr_cx", bus.cursor_x_o, 0);
        chk("scr_cy", bus.cursor_y_o, 24);
        for (int r = 1; r < ROWS; r++)
            for (int c = 0; c < COLS; c += 13) begin
                chk("scr_char", sram[{5'(r - 1), 7'(c)}], r);
                chk("scr_colr", cram[{5'(r - 1), 7'(c)}], r ^ 8'hA5);
            end
        for (int c = 0; c < COLS; c += 7) begin
            chk("scr_blank_char", sram[{5'd24, 7'(c)}], 8'h20);
            chk("scr_blank_colr", cram[{5'd24, 7'(c)}], 8'h4F);
        end

        send(8'h0C, 8'h2C, 1'b1, busy);
        chk("ff_busy", busy, 2000);
        chk("ff_cx", bus.cursor_x_o, 0);
        chk("ff_cy", bus.cursor_y_o, 0);
        chk("ff_cell", {sram[12'h628], cram[12'h628]}, 16'h202C);

        repeat (24) send(8'h0A, 8'h07, 1'b1, busy);
        send(8'h7A, 8'h07, 1'b1, busy);
        send(8'h0A, 8'h1F, 1'b0, busy);
        repeat (1000) @(negedge clk);
        chk("pre_abort_cy", bus.cursor_y_o, 24);
        #2 rst = 1'b1;
        #1;
        chk("abort_addr", bus.addr_o, 0);
        chk("abort_wren", bus.wren_o, 0);
        chk("abort_ready", bus.char_ready_o, 0);
        chk("abort_data", {bus.char_data_o, bus.colr_data_o}, 0);
        chk("abort_cx", bus.cursor_x_o, 0);
        chk("abort_cy", bus.cursor_y_o, 0);
        expq.delete();
        mx = 0;
        my = 0;
        mclear(8'h70);
        w0 = nwr;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        wait_ready(5000);
        chk("reclear_ready", bus.char_ready_o, 1);
        chk("reclear_nwr", nwr - w0, 2000);
        chk("reclear_left", expq.size(), 0);
        chk("reclear_cx", bus.cursor_x_o, 0);
        chk("reclear_cy", bus.cursor_y_o, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
